hazard_scoreboard: RTL and testbench

// Consumes the decode-stage control signals (register read ids, required stages, write id/source, MDU use/start).

---
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard for the 5-stage MIPS pipeline: tracks E/M/W writers and the MDU busy window,
// and drives the D stall and the operand forward selects. Optional stall counter: HAZARD_STALL_COUNTER_EN.
module hazard_scoreboard #(
  parameter int unsigned REG_ID_WIDTH = 5,
  parameter int unsigned MUL_CYCLES   = 5,
  parameter int unsigned DIV_CYCLES   = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    decValid,
  input  logic [REG_ID_WIDTH-1:0] decRead1Id,
  input  logic [1:0]              decRead1Stage,
  input  logic [REG_ID_WIDTH-1:0] decRead2Id,
  input  logic [1:0]              decRead2Stage,
  input  logic                    decWriteEnabled,
  input  logic [REG_ID_WIDTH-1:0] decWriteId,
  input  logic [1:0]              decWriteReady,
  input  logic                    decMduUse,
  input  logic                    decMduStart,
  input  logic                    decMduIsDiv,
  output logic                    stall,
  output logic [1:0]              fwdSel1,
  output logic [1:0]              fwdSel2,
  output logic                    mduBusy,
  output logic [31:0]             stallCycles
);

  localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef struct packed {
    logic                    valid;
    logic [REG_ID_WIDTH-1:0] id;
    logic [1:0]              ready;
  } entry_t;

  entry_t           ent_e;
  entry_t           ent_m;
  entry_t           ent_w;
  entry_t           dec_ent;
  logic [CNT_W-1:0] mdu_cnt;
  logic [2:0]       op1;
  logic [2:0]       op2;
  logic             mdu_stall;
  logic             issue;

  // Returns {stall, fwd_sel} for one operand against the youngest matching in-flight writer.
  function automatic logic [2:0] lookup(input logic [REG_ID_WIDTH-1:0] id, input logic [1:0] need,
                                        input entry_t e, input entry_t m, input entry_t w);
    logic       hit;
    logic [1:0] p;
    logic [1:0] r;
    logic [2:0] res;
    hit = 1'b0;
    p   = 2'd0;
    r   = 2'd0;
    if (id != '0 && need != 2'd3) begin
      if (e.valid && e.id == id) begin
        hit = 1'b1; p = 2'd1; r = e.ready;
      end else if (m.valid && m.id == id) begin
        hit = 1'b1; p = 2'd2; r = m.ready;
      end else if (w.valid && w.id == id) begin
        hit = 1'b1; p = 2'd3; r = w.ready;
      end
    end
    res[2]   = hit && ((3'(p) + 3'(need)) <= 3'(r));
    res[1:0] = (hit && need == 2'd0 && p > r) ? p : 2'd0;
    return res;
  endfunction

  always_comb begin
    dec_ent       = '0;
    dec_ent.valid = decWriteEnabled && (decWriteId != '0);
    dec_ent.id    = decWriteId;
    dec_ent.ready = decWriteReady;
    op1           = lookup(decRead1Id, decRead1Stage, ent_e, ent_m, ent_w);
    op2           = lookup(decRead2Id, decRead2Stage, ent_e, ent_m, ent_w);
  end

  assign mduBusy   = (mdu_cnt != '0);
  assign mdu_stall = decMduUse && mduBusy;
  assign stall     = decValid && (op1[2] || op2[2] || mdu_stall);
  assign fwdSel1   = decValid ? op1[1:0] : 2'd0;
  assign fwdSel2   = decValid ? op2[1:0] : 2'd0;
  assign issue     = decValid && !stall;

  // Writer pipeline and MDU busy counter; a new start reloads even while counting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent_e   <= '0;
      ent_m   <= '0;
      ent_w   <= '0;
      mdu_cnt <= '0;
    end else begin
      ent_w <= ent_m;
      ent_m <= ent_e;
      ent_e <= issue ? dec_ent : '0;
      if (issue && decMduStart) begin
        mdu_cnt <= decMduIsDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
      end else if (mdu_cnt != '0) begin
        mdu_cnt <= mdu_cnt - CNT_W'(1);
      end
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stallCycles = stall_cnt;
`else
  assign stallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: issue-history model checked every cycle plus directed literal checks.
module tb_hazard_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        decValid;
  logic [4:0]  decRead1Id;
  logic [1:0]  decRead1Stage;
  logic [4:0]  decRead2Id;
  logic [1:0]  decRead2Stage;
  logic        decWriteEnabled;
  logic [4:0]  decWriteId;
  logic [1:0]  decWriteReady;
  logic        decMduUse;
  logic        decMduStart;
  logic        decMduIsDiv;
  logic        stall;
  logic [1:0]  fwdSel1;
  logic [1:0]  fwdSel2;
  logic        mduBusy;
  logic [31:0] stallCycles;

  hazard_scoreboard dut (
    .clock(clock), .reset(reset), .decValid(decValid),
    .decRead1Id(decRead1Id), .decRead1Stage(decRead1Stage),
    .decRead2Id(decRead2Id), .decRead2Stage(decRead2Stage),
    .decWriteEnabled(decWriteEnabled), .decWriteId(decWriteId), .decWriteReady(decWriteReady),
    .decMduUse(decMduUse), .decMduStart(decMduStart), .decMduIsDiv(decMduIsDiv),
    .stall(stall), .fwdSel1(fwdSel1), .fwdSel2(fwdSel2), .mduBusy(mduBusy), .stallCycles(stallCycles)
  );

  always #5 clock = ~clock;

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: every issued GPR writer remembered with the cycle it issued; its age is its stage.
  typedef struct { int unsigned cyc; logic [4:0] id; logic [1:0] rdy; } wr_t;
  wr_t         wq[$];
  int unsigned now = 0;
  int unsigned mdu_until = 0;
  bit          mdu_any = 1'b0;
  longint      exp_cnt = 0;

  function automatic bit busy_model();
    return mdu_any && (now <= mdu_until);
  endfunction

  function automatic void op_model(input logic [4:0] id, input logic [1:0] n,
                                   output bit st, output logic [1:0] fs);
    int unsigned age;
    st = 1'b0;
    fs = 2'd0;
    if (id == 5'd0 || n == 2'd3) return;
    for (int k = wq.size() - 1; k >= 0; k--) begin
      age = now - wq[k].cyc;
      if (age >= 1 && age <= 3 && wq[k].id == id) begin
        st = (age + int'(n)) <= int'(wq[k].rdy);
        if (n == 2'd0 && age > int'(wq[k].rdy)) fs = 2'(age);
        return;
      end
    end
  endfunction

  function automatic void eval_model(output bit st, output logic [1:0] f1, output logic [1:0] f2);
    bit s1;
    bit s2;
    op_model(decRead1Id, decRead1Stage, s1, f1);
    op_model(decRead2Id, decRead2Stage, s2, f2);
    st = decValid && (s1 || s2 || (decMduUse && busy_model()));
    if (!decValid) begin
      f1 = 2'd0;
      f2 = 2'd0;
    end
  endfunction

  always @(posedge clock or posedge reset) begin
    bit         st;
    logic [1:0] a;
    logic [1:0] b;
    if (reset) begin
      wq.delete();
      mdu_any = 1'b0;
      exp_cnt = 0;
      now     = 0;
    end else begin
      eval_model(st, a, b);
      if (st && exp_cnt != 64'hFFFF_FFFF) exp_cnt++;
      if (decValid && !st) begin
        if (decWriteEnabled && decWriteId != 5'd0)
          wq.push_back('{now, decWriteId, decWriteReady});
        if (decMduStart) begin
          mdu_any   = 1'b1;
          mdu_until = now + (decMduIsDiv ? 10 : 5);
        end
      end
      now++;
      while (wq.size() > 0 && (now - wq[0].cyc) > 3) void'(wq.pop_front());
    end
  end

  always @(negedge clock) begin
    bit         st;
    logic [1:0] a;
    logic [1:0] b;
    if (chk_en) begin
      eval_model(st, a, b);
      chk("model_stall", stall, st);
      chk("model_mduBusy", mduBusy, busy_model());
      if (!st) begin
        chk("model_fwdSel1", fwdSel1, a);
        chk("model_fwdSel2", fwdSel2, b);
      end
`ifdef HAZARD_STALL_COUNTER_EN
      chk("model_stallCycles", stallCycles, exp_cnt);
`else
      chk("model_stallCycles", stallCycles, 0);
`endif
    end
  end

  task automatic set_in(input logic v, input logic [4:0] r1, input logic [1:0] s1,
                        input logic [4:0] r2, input logic [1:0] s2,
                        input logic we, input logic [4:0] wid, input logic [1:0] rdy,
                        input logic mu, input logic ms, input logic md);
    decValid = v; decRead1Id = r1; decRead1Stage = s1; decRead2Id = r2; decRead2Stage = s2;
    decWriteEnabled = we; decWriteId = wid; decWriteReady = rdy;
    decMduUse = mu; decMduStart = ms; decMduIsDiv = md;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) step();
    @(negedge clock);
    chk("reset_stall", stall, 0);
    chk("reset_mduBusy", mduBusy, 0);
    chk("reset_stallCycles", stallCycles, 0);
    step();
    reset  = 1'b0;
    chk_en = 1'b1;

    // 1: addu $1 then beq $1,$0
    set_in(1, 5'd0, 2'd3, 5'd0, 2'd3, 1, 5'd1, 2'd1, 0, 0, 0);
    step();
    set_in(1, 5'd1, 2'd0, 5'd0, 2'd0, 0, 5'd0, 2'd0, 0, 0, 0);
    @(negedge clock); chk("t1_stall", stall, 1);
    step();
    @(negedge clock); chk("t1_stall_after", stall, 0); chk("t1_fwd1", fwdSel1, 2);
    step();
    drain();

    // 2: lw $2 then addu $3,$2,$2 in E
    set_in(1, 5'd0, 2'd1, 5'd0, 2'd3, 1, 5'd2, 2'd2, 0, 0, 0);
    step();
    set_in(1, 5'd2, 2'd1, 5'd2, 2'd1, 1, 5'd3, 2'd1, 0, 0, 0);
    @(negedge clock); chk("t2_stall", stall, 1);
    step();
    @(negedge clock); chk("t2_stall_after", stall, 0);
    chk("t2_fwd1", fwdSel1, 0); chk("t2_fwd2", fwdSel2, 0);
    step();
    drain();

    // 3: lw $3 then sw $3 data needed in M
    set_in(1, 5'd0, 2'd1, 5'd0, 2'd3, 1, 5'd3, 2'd2, 0, 0, 0);
    step();
    set_in(1, 5'd0, 2'd1, 5'd3, 2'd2, 0, 5'd0, 2'd0, 0, 0, 0);
    @(negedge clock); chk("t3_stall", stall, 0); chk("t3_fwd2", fwdSel2, 0);
    step();
    drain();

    // 4: lw $4, addu $4, jr $4 -- youngest (E) wins
    set_in(1, 5'd0, 2'd1, 5'd0, 2'd3, 1, 5'd4, 2'd2, 0, 0, 0);
    step();
    set_in(1, 5'd0, 2'd3, 5'd0, 2'd3, 1, 5'd4, 2'd1, 0, 0, 0);
    step();
    set_in(1, 5'd4, 2'd0, 5'd0, 2'd3, 0, 5'd0, 2'd0, 0, 0, 0);
    @(negedge clock); chk("t4_stall", stall, 1);
    step();
    @(negedge clock); chk("t4_stall_after", stall, 0); chk("t4_fwd1", fwdSel1, 2);
    step();
    drain();

    // decValid=0 masks a hazard; then M-stage load stalls and W forwards
    set_in(1, 5'd0, 2'd1, 5'd0, 2'd3, 1, 5'd6, 2'd2, 0, 0, 0);
    step();
    set_in(0, 5'd6, 2'd0, 5'd0, 2'd3, 0, 5'd0, 2'd0, 0, 0, 0);
    @(negedge clock); chk("inv_stall", stall, 0); chk("inv_fwd1", fwdSel1, 0);
    step();
    set_in(1, 5'd6, 2'd0, 5'd0, 2'd3, 0, 5'd0, 2'd0, 0, 0, 0);
    @(negedge clock); chk("m_load_stall", stall, 1);
    step();
    @(negedge clock); chk("w_stall", stall, 0); chk("w_fwd1", fwdSel1, 3);
    step();
    drain();

    // 5: mult then mflo, divu then mflo
    for (int d = 0; d < 2; d++) begin
      set_in(1, 5'd8, 2'd1, 5'd9, 2'd1, 0, 5'd0, 2'd0, 1, 1, 1'(d));
      @(negedge clock); chk("t5_start_stall", stall, 0);
      step();
      set_in(1, 5'd0, 2'd3, 5'd0, 2'd3, 1, 5'd5, 2'd1, 1, 0, 0);
      for (int i = 0; i < (d == 0 ? 5 : 10); i++) begin
        @(negedge clock); chk("t5_busy_stall", stall, 1); chk("t5_busy", mduBusy, 1);
        step();
      end
      @(negedge clock); chk("t5_done_stall", stall, 0); chk("t5_done_busy", mduBusy, 0);
      step();
      drain();
    end

    // 6: reset three cycles into a divide
    set_in(1, 5'd0, 2'd3, 5'd0, 2'd3, 0, 5'd0, 2'd0, 1, 1, 1);
    step();
    idle();
    repeat (3) step();
    set_in(1, 5'd0, 2'd3, 5'd0, 2'd3, 1, 5'd5, 2'd1, 1, 0, 0);
    @(negedge clock); chk("t6_pre_stall", stall, 1);
    step();
    reset = 1'b1;
    #1;
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_busy", mduBusy, 0);
    chk("t6_rst_fwd1", fwdSel1, 0);
    chk("t6_rst_stallCycles", stallCycles, 0);
    step();
    reset = 1'b0;
    // write to $0 followed by a read of $0
    set_in(1, 5'd0, 2'd3, 5'd0, 2'd3, 1, 5'd0, 2'd1, 0, 0, 0);
    step();
    set_in(1, 5'd0, 2'd0, 5'd0, 2'd0, 0, 5'd0, 2'd0, 0, 0, 0);
    @(negedge clock); chk("t6_zero_stall", stall, 0); chk("t6_zero_fwd1", fwdSel1, 0);
    step();
    drain();

    @(negedge clock);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
